// File: rtl/spu_sp_pkg.sv
// Shared single-precision constants, field layout and divide FSM encoding for the SP pipe.
package spu_sp_pkg;

  localparam int          EXP_W   = 8;
  localparam int          FRAC_W  = 23;
  localparam int          SP_BIAS = 127;
  localparam logic [31:0] SP_SMAX = 32'h7F7FFFFF;
  localparam logic [31:0] SP_SMIN = 32'h00800000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } div_state_t;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [FRAC_W:0]  m;
  } sp_fields_t;

  // Hidden one is always set; a zero exponent is caught separately as a zero operand.
  function automatic sp_fields_t sp_unpack(input logic [31:0] w);
    sp_fields_t f;
    f.s = w[31];
    f.e = w[30:23];
    f.m = {1'b1, w[22:0]};
    return f;
  endfunction

endpackage

// File: rtl/spu_fp_div_lane.sv
// One lane of the SP divide: operand unpack, restoring radix-2 iteration and final pack/clamp.
module spu_fp_div_lane
  import spu_sp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        iter,
  input  logic        pack,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q_word
);

  sp_fields_t        fa, fb;
  logic [24:0]       rem, quo;
  logic [23:0]       mb;
  logic              sgn, a_zero, b_zero;
  logic signed [9:0] exp10, exp_n;
  logic [22:0]       frac;
  logic              ge;
  logic [24:0]       diff;
  logic [31:0]       pack_word;

  assign fa   = sp_unpack(a);
  assign fb   = sp_unpack(b);
  assign ge   = rem >= {1'b0, mb};
  assign diff = rem - {1'b0, mb};

  // Quotient lies in (0.5, 2): a clear integer bit means one extra normalise shift.
  always_comb begin
    exp_n = exp10;
    frac  = quo[23:1];
    if (!quo[24]) begin
      frac  = quo[22:0];
      exp_n = exp10 - 10'sd1;
    end
  end

  always_comb begin
    pack_word = {sgn, exp_n[7:0], frac};
    if (a_zero)                 pack_word = 32'h0;
    else if (b_zero)            pack_word = {sgn, SP_SMAX[30:0]};
    else if (exp_n > 10'sd254)  pack_word = {sgn, SP_SMAX[30:0]};
    else if (exp_n < 10'sd1)    pack_word = 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem    <= '0;
      quo    <= '0;
      mb     <= '0;
      sgn    <= 1'b0;
      a_zero <= 1'b0;
      b_zero <= 1'b0;
      exp10  <= '0;
      q_word <= '0;
    end else begin
      if (load) begin
        rem    <= {1'b0, fa.m};
        quo    <= '0;
        mb     <= fb.m;
        sgn    <= fa.s ^ fb.s;
        a_zero <= (fa.e == '0);
        b_zero <= (fb.e == '0);
        exp10  <= 10'(fa.e) - 10'(fb.e) + 10'(SP_BIAS);
      end else if (iter) begin
        quo <= {quo[23:0], ge};
        rem <= (ge ? diff : rem) << 1;
      end
      if (pack) q_word <= pack_word;
    end
  end

endmodule

// File: rtl/spu_fp_divide_seq.sv
// Multi-cycle 4-lane SP divide: shared FSM and iteration counter driving lockstep lanes.
module spu_fp_divide_seq
  import spu_sp_pkg::*;
#(
  parameter int LANES = 4,
  parameter int QBITS = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*32-1:0] ra,
  input  logic [LANES*32-1:0] rb,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*32-1:0] result
);

  div_state_t            state, state_nxt;
  logic [4:0]            cnt;
  logic                  load, iter, pack, last;
  logic [LANES-1:0][31:0] lane_q;

  assign last = (cnt == 5'(QBITS-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = DIV;
      DIV:     if (last)      state_nxt = PACK;
      PACK:                   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    load      = in_ready & in_valid;
    iter      = (state == DIV);
    pack      = (state == PACK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (load)           cnt <= '0;
    else if (iter && last)   cnt <= '0;
    else if (iter)           cnt <= cnt + 5'd1;
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    spu_fp_div_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .iter   (iter),
      .pack   (pack),
      .a      (ra[j*32 +: 32]),
      .b      (rb[j*32 +: 32]),
      .q_word (lane_q[j])
    );
  end

  assign result = lane_q;

endmodule
